// File: rtl/fc_irq_pkg.sv
// Shared defaults for the fabric-controller interrupt dispatcher.
package fc_irq_pkg;

    localparam int NB_IRQ_DEF         = 32;
    localparam int FC_EVT_LINE        = 26;
    localparam int EVT_FIFO_DEPTH_DEF = 4;

endpackage

// File: rtl/fc_irq_evt_fifo.sv
// Event-id FIFO: registered pointers, head visible combinationally (0 when empty).
// Push on full is dropped and latches ovf_o; pop on empty is ignored.
module fc_irq_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             ovf_clr_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             ovf_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count == DEPTH_C);
    assign empty_o = (count == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = empty_o ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_o  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // a dropped push in the same cycle as a clear must stay visible
            if (push_i && full_o) begin
                ovf_o <= 1'b1;
            end else if (ovf_clr_i) begin
                ovf_o <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fc_irq_dispatch.sv
// Interrupt capture, mask and fixed-priority (highest index) dispatch to the core.
// Outputs registered one cycle after pending/mask; no backpressure beyond ack, event FIFO drops on full.
module fc_irq_dispatch
    import fc_irq_pkg::*;
#(
    parameter int                 NB_IRQ         = NB_IRQ_DEF,
    parameter int                 EVENT_ID_WIDTH = 8,
    parameter int                 FIFO_DEPTH     = EVT_FIFO_DEPTH_DEF,
    parameter int                 EVT_LINE       = FC_EVT_LINE,
    parameter bit                 IRQ_EDGE       = 1'b1,
    parameter logic [NB_IRQ-1:0]  MASK_RST       = '1,
    localparam int                ID_W           = $clog2(NB_IRQ)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NB_IRQ-1:0]         irq_i,
    input  logic                      mask_we_i,
    input  logic [NB_IRQ-1:0]         mask_wdata_i,
    output logic [NB_IRQ-1:0]         mask_o,
    input  logic                      evt_valid_i,
    input  logic [EVENT_ID_WIDTH-1:0] evt_data_i,
    output logic                      evt_fulln_o,
    input  logic                      evt_pop_i,
    output logic [EVENT_ID_WIDTH-1:0] evt_data_o,
    output logic                      evt_empty_o,
    output logic                      evt_ovf_o,
    input  logic                      evt_ovf_clr_i,
    output logic                      core_irq_req_o,
    output logic [ID_W-1:0]           core_irq_id_o,
    output logic [NB_IRQ-1:0]         core_irq_x_o,
    input  logic                      core_irq_ack_i,
    input  logic [ID_W-1:0]           core_irq_ack_id_i,
    output logic [NB_IRQ-1:0]         pending_o
);

    localparam logic [NB_IRQ-1:0] ONE     = {{(NB_IRQ-1){1'b0}}, 1'b1};
    localparam logic [NB_IRQ-1:0] EVT_BIT = ONE << EVT_LINE;

    logic [NB_IRQ-1:0] irq_q;
    logic [NB_IRQ-1:0] pending_q;
    logic [NB_IRQ-1:0] pending_d;
    logic [NB_IRQ-1:0] ack_vec;
    logic [NB_IRQ-1:0] masked;
    logic [NB_IRQ-1:0] mask_q;
    logic              evt_full;
    logic              req_d;
    logic [ID_W-1:0]   id_d;

    fc_irq_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVENT_ID_WIDTH)
    ) u_evt_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (evt_valid_i),
        .data_i    (evt_data_i),
        .pop_i     (evt_pop_i),
        .ovf_clr_i (evt_ovf_clr_i),
        .data_o    (evt_data_o),
        .full_o    (evt_full),
        .empty_o   (evt_empty_o),
        .ovf_o     (evt_ovf_o)
    );

    assign evt_fulln_o = !evt_full;
    assign mask_o      = mask_q;

    // The event line is a pure level view of the FIFO; its register bit is kept at 0.
    assign pending_o = (pending_q & ~EVT_BIT) | (evt_empty_o ? '0 : EVT_BIT);

    always_comb begin
        ack_vec = '0;
        if (core_irq_ack_i && IRQ_EDGE) begin
            for (int i = 0; i < NB_IRQ; i++) begin
                if (core_irq_ack_id_i == ID_W'(i)) begin
                    ack_vec[i] = 1'b1;
                end
            end
        end
        ack_vec = ack_vec & ~EVT_BIT;
    end

    always_comb begin
        pending_d = '0;
        if (IRQ_EDGE) begin
            // a fresh rising edge beats an ack on the same line
            pending_d = (pending_q & ~ack_vec) | (irq_i & ~irq_q);
        end else begin
            pending_d = irq_i;
        end
        pending_d = pending_d & ~EVT_BIT;
    end

    // Arbitrate without the bit being acked so req never lingers on a serviced line.
    always_comb begin
        masked = pending_o & mask_q & ~ack_vec;
        req_d  = |masked;
        id_d   = '0;
        for (int i = 0; i < NB_IRQ; i++) begin
            if (masked[i]) begin
                id_d = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_q          <= '0;
            pending_q      <= '0;
            mask_q         <= MASK_RST;
            core_irq_req_o <= 1'b0;
            core_irq_id_o  <= '0;
            core_irq_x_o   <= '0;
        end else begin
            irq_q          <= irq_i;
            pending_q      <= pending_d;
            core_irq_req_o <= req_d;
            core_irq_x_o   <= req_d ? (ONE << id_d) : '0;
            if (mask_we_i) begin
                mask_q <= mask_wdata_i;
            end
            if (req_d) begin
                core_irq_id_o <= id_d;
            end
        end
    end

endmodule
